// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage access unit.
// MEM_TIMEOUT_EN enables the WAIT-state watchdog.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_WAIT = 2'd1,
    MEM_ST_DONE = 2'd2
  } mem_state_e;

  localparam logic [31:0] MEM_TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory port: registered request side, ack/rdata response side.
// Master is the MEM stage, slave is the memory.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 17
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/mem_watchdog.sv
// WAIT-state cycle counter; flags the last allowed cycle.
// Instantiated by mem_access_unit only when MEM_TIMEOUT_EN is defined.
module mem_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // Held at zero outside WAIT, so entering WAIT starts from 0.
  always_comb begin
    cnt_d = '0;
    if (en) cnt_d = cnt_q + 1'b1;
  end

  assign expired =
    en && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: EX/MEM load/store to req/ack memory port.
// Define MEM_TIMEOUT_EN to bound WAIT with mem_watchdog.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W         = 17,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        memread_mem,
  input  logic        memwrite_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] write_data_memory_mem,
  input  logic        alu_ready,
  output logic        data_ready_mem,
  output logic [31:0] data_from_memory_mem,
  mem_access_unit_if.master mem,
  output logic        misalign_err,
  output logic [31:0] misalign_addr,
  output logic        timeout_err
);

  mem_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              merr_q, merr_d;
  logic [31:0]       maddr_q, maddr_d;
  logic              access;
  logic              misaligned;
  logic              tmo;

  assign access     = memread_mem | memwrite_mem;
  assign misaligned = access & (|alu_result_mem[1:0]);

`ifdef MEM_TIMEOUT_EN
  logic terr_q, terr_d;

  mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rstn   (rstn),
    .en     (state_q == MEM_ST_WAIT),
    .expired(tmo)
  );

  assign terr_d = terr_q | (tmo & ~mem.mem_ack);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) terr_q <= 1'b0;
    else       terr_q <= terr_d;
  end

  assign timeout_err = terr_q;
`else
  logic unused_cfg;

  assign unused_cfg  = TIMEOUT_CYCLES[0];
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    merr_d         = merr_q;
    maddr_d        = maddr_q;
    data_ready_mem = 1'b1;
    case (state_q)
      MEM_ST_IDLE: begin
        data_ready_mem = ~access | misaligned;
        if (misaligned) begin
          // Misaligned ops pass through without touching memory.
          merr_d = 1'b1;
          if (!merr_q) maddr_d = alu_result_mem;
        end else if (access) begin
          state_d = MEM_ST_WAIT;
          req_d   = 1'b1;
          we_d    = memwrite_mem;
          addr_d  = alu_result_mem[ADDR_W+1:2];
          wdata_d = write_data_memory_mem;
        end
      end
      MEM_ST_WAIT: begin
        data_ready_mem = 1'b0;
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          state_d = MEM_ST_DONE;
          if (!we_q) rdata_d = mem.mem_rdata;
        end else if (tmo) begin
          req_d   = 1'b0;
          state_d = MEM_ST_DONE;
          if (!we_q) rdata_d = MEM_TIMEOUT_DATA;
        end
      end
      MEM_ST_DONE: begin
        // Hold here while frozen so the op is never re-issued.
        if (alu_ready) state_d = MEM_ST_IDLE;
      end
      default: state_d = MEM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= MEM_ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      merr_q  <= 1'b0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      merr_q  <= merr_d;
      maddr_q <= maddr_d;
    end
  end

  assign mem.mem_req           = req_q;
  assign mem.mem_we            = we_q;
  assign mem.mem_addr          = addr_q;
  assign mem.mem_wdata         = wdata_q;
  assign data_from_memory_mem  = rdata_q;
  assign misalign_err          = merr_q;
  assign misalign_addr         = maddr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases then random transactions.
// Define MEM_TIMEOUT_EN to also exercise the WAIT watchdog.
module tb_mem_access_unit;

  localparam int unsigned AW = 17;

  logic        clk;
  logic        rstn;
  logic        memread_mem;
  logic        memwrite_mem;
  logic [31:0] alu_result_mem;
  logic [31:0] write_data_memory_mem;
  logic        alu_ready;
  logic        data_ready_mem;
  logic [31:0] data_from_memory_mem;
  logic        misalign_err;
  logic [31:0] misalign_addr;
  logic        timeout_err;

  mem_access_unit_if #(.ADDR_W(AW)) bus ();

  mem_access_unit #(
    .ADDR_W        (AW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .memread_mem          (memread_mem),
    .memwrite_mem         (memwrite_mem),
    .alu_result_mem       (alu_result_mem),
    .write_data_memory_mem(write_data_memory_mem),
    .alu_ready            (alu_ready),
    .data_ready_mem       (data_ready_mem),
    .data_from_memory_mem (data_from_memory_mem),
    .mem                  (bus.master),
    .misalign_err         (misalign_err),
    .misalign_addr        (misalign_addr),
    .timeout_err          (timeout_err)
  );

  int n_chk;
  int n_pass;
  int req_pulses;
  logic req_prev;

  // Reference model state (transaction level).
  logic [31:0] exp_data;
  logic        exp_merr;
  logic [31:0] exp_maddr;
  logic        exp_terr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL time_limit: bench did not finish");
    $fatal(1);
  end

  initial begin
    req_pulses = 0;
    req_prev   = 1'b0;
  end

  always @(posedge clk) begin
    if (bus.mem_req && !req_prev) req_pulses++;
    req_prev = bus.mem_req;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at a negedge with the unit idle; returns at a negedge idle.
  task automatic do_access(input logic rd, input logic wr,
                           input logic [31:0] addr,
                           input logic [31:0] wd,
                           input logic [31:0] rdat,
                           input int k, input int stall);
    int low;
    int p0;
    logic [31:0] ea;
    p0 = req_pulses;
    ea = 32'(addr[AW+1:2]);
    memread_mem = rd;
    memwrite_mem = wr;
    alu_result_mem = addr;
    write_data_memory_mem = wd;
    alu_ready = 1'b1;
    #1;
    if (addr[1:0] != 2'b00) begin
      chk("rdy_misaligned", 32'(data_ready_mem), 1);
      @(negedge clk);
      chk("req_misaligned", 32'(bus.mem_req), 0);
      if (!exp_merr) exp_maddr = addr;
      exp_merr = 1'b1;
      chk("merr", 32'(misalign_err), 1);
      chk("maddr", misalign_addr, exp_maddr);
      chk("data_kept_mis", data_from_memory_mem, exp_data);
    end else begin
      low = 0;
      chk("rdy_idle_access", 32'(data_ready_mem), 0);
      if (!data_ready_mem) low++;
      @(negedge clk);
      chk("req_issued", 32'(bus.mem_req), 1);
      chk("mem_we", 32'(bus.mem_we), 32'(wr));
      chk("mem_addr", 32'(bus.mem_addr), ea);
      if (wr) chk("mem_wdata", bus.mem_wdata, wd);
      for (int i = 1; i <= k; i++) begin
        if (!data_ready_mem) low++;
        if (i == k) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = rdat;
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.mem_rdata = $urandom;
      end
      if (rd && !wr) exp_data = rdat;
      chk("low_cycles", 32'(low), 32'(k + 1));
      chk("rdy_done", 32'(data_ready_mem), 1);
      chk("req_dropped", 32'(bus.mem_req), 0);
      chk("load_data", data_from_memory_mem, exp_data);
      chk("terr", 32'(timeout_err), 32'(exp_terr));
      for (int s = 0; s < stall; s++) begin
        alu_ready = 1'b0;
        @(negedge clk);
        chk("rdy_stall", 32'(data_ready_mem), 1);
        chk("req_stall", 32'(bus.mem_req), 0);
      end
      alu_ready = 1'b1;
    end
    memread_mem = 1'b0;
    memwrite_mem = 1'b0;
    @(negedge clk);
    chk("rdy_after", 32'(data_ready_mem), 1);
    chk("req_pulses", 32'(req_pulses - p0),
        (addr[1:0] != 2'b00) ? 32'd0 : 32'd1);
  endtask

  initial begin
    int kind;
    logic rd;
    logic wr;
    logic [31:0] a;
    n_chk = 0;
    n_pass = 0;
    rstn = 1'b0;
    memread_mem = 1'b0;
    memwrite_mem = 1'b0;
    alu_result_mem = '0;
    write_data_memory_mem = '0;
    alu_ready = 1'b1;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    exp_data = '0;
    exp_merr = 1'b0;
    exp_maddr = '0;
    exp_terr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(data_ready_mem), 1);
    chk("rst_req", 32'(bus.mem_req), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_data", data_from_memory_mem, 0);
    chk("rst_merr", 32'(misalign_err), 0);
    chk("rst_maddr", misalign_addr, 0);
    chk("rst_terr", 32'(timeout_err), 0);
    rstn = 1'b1;
    @(negedge clk);

    do_access(1, 0, 32'h10, 32'h0, 32'h1234_5678, 3, 0);
    do_access(0, 1, 32'h20, 32'hCAFE_F00D, 32'h0BAD_0BAD, 1, 0);
    do_access(1, 0, 32'h30, 32'h0, 32'hA5A5_0001, 2, 5);
    do_access(1, 0, 32'h13, 32'h0, 32'h0, 1, 0);
    do_access(0, 1, 32'h21, 32'h55, 32'h0, 1, 0);
    chk("maddr_first_kept", misalign_addr, 32'h13);

    // Reset while a load is outstanding.
    memread_mem = 1'b1;
    alu_result_mem = 32'h40;
    @(negedge clk);
    chk("rw_req_before", 32'(bus.mem_req), 1);
    #2 rstn = 1'b0;
    #1;
    chk("rw_req_async", 32'(bus.mem_req), 0);
    chk("rw_rdy_pending", 32'(data_ready_mem), 0);
    memread_mem = 1'b0;
    #1;
    chk("rw_rdy_idle", 32'(data_ready_mem), 1);
    exp_data = '0;
    exp_merr = 1'b0;
    exp_maddr = '0;
    exp_terr = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rw_rdy_release", 32'(data_ready_mem), 1);
    chk("rw_merr", 32'(misalign_err), 0);

`ifdef MEM_TIMEOUT_EN
    memread_mem = 1'b1;
    alu_result_mem = 32'h80;
    @(negedge clk);
    repeat (7) @(negedge clk);
    chk("to_wait8_rdy", 32'(data_ready_mem), 0);
    chk("to_wait8_terr", 32'(timeout_err), 0);
    @(negedge clk);
    exp_data = 32'hDEAD_BEEF;
    exp_terr = 1'b1;
    chk("to_terr", 32'(timeout_err), 1);
    chk("to_data", data_from_memory_mem, exp_data);
    chk("to_rdy_done", 32'(data_ready_mem), 1);
    chk("to_req", 32'(bus.mem_req), 0);
    memread_mem = 1'b0;
    @(negedge clk);
`endif

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      rd = (kind != 1);
      wr = (kind != 0);
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      else a[1:0] = 2'b00;
      do_access(rd, wr, a, $urandom, $urandom,
                $urandom_range(1, 4), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage controller between the EX/MEM and MEM/WB pipeline registers. It turns the EX/MEM load/store controls into a req/ack transaction on the data-memory port. It returns load data on data_from_memory_mem and drives data_ready_mem low to freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB until the access completes. It also enforces single issue per instruction while the pipeline is frozen for any reason, including alu_ready low.

Parameters:
ADDR_W, 17, word-address width on the memory port (byte address bits [ADDR_W+1:2]).
TIMEOUT_CYCLES, 1024, WAIT-state cycle limit; used only with MEM_TIMEOUT_EN.

Ports:
clk  input  1  core clock
rstn  input  1  reset; asynchronous assert, active-low
memread_mem  input  1  load pending (EX/MEM output)
memwrite_mem  input  1  store pending (EX/MEM output)
alu_result_mem  input  32  byte address
write_data_memory_mem  input  32  store data
alu_ready  input  1  EX-stage ready; 0 freezes the pipeline
data_ready_mem  output  1  1 = MEM stage may advance
data_from_memory_mem  output  32  load result, held until the next load completes
mem_req  output  1  request, registered
mem_we  output  1  1 = write, registered
mem_addr  output  ADDR_W  word address, registered
mem_wdata  output  32  write data, registered
mem_rdata  input  32  read data, valid with mem_ack
mem_ack  input  1  one-cycle completion strobe
misalign_err  output  1  sticky, addr[1:0] != 0 on an access
misalign_addr  output  32  byte address of the first misaligned access
timeout_err  output  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values: state IDLE; mem_req, mem_we, misalign_err and timeout_err 0; mem_addr, mem_wdata, data_from_memory_mem and misalign_addr 0. data_ready_mem follows the IDLE rule below, so it is 1 while EX/MEM holds no memory operation.
- Access definition: access = memread_mem | memwrite_mem. If both are set, it is a write.
- States: IDLE, WAIT, DONE.
- IDLE, combinational output: data_ready_mem = ~access | misaligned.
- IDLE, aligned access: at the clock edge go to WAIT. Register mem_req=1, mem_we=memwrite_mem, mem_addr=alu_result_mem[ADDR_W+1:2] and mem_wdata.
- IDLE, misaligned access: no request is issued and no state change occurs. misalign_err is set. misalign_addr is captured only when misalign_err was 0. The instruction passes through; a load returns the previous data_from_memory_mem.
- WAIT: data_ready_mem=0, and mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - On mem_ack: mem_req<=0; for a read, data_from_memory_mem<=mem_rdata; go to DONE.
  - mem_ack outside WAIT is ignored.
- DONE: data_ready_mem=1.
  - alu_ready=1: go to IDLE. The pipeline advances on this same edge.
  - alu_ready=0: stay in DONE. The operation is not re-issued.
- Latency: an aligned access with ack k cycles after the request holds data_ready_mem low for k+1 cycles (the IDLE cycle plus WAIT), then DONE for one cycle or more. Minimum 2 low cycles, since k≥1.
- Back-to-back accesses: each one enters IDLE, so there is one IDLE cycle between transactions.
- Reset during WAIT: mem_req drops at once and the FSM returns to IDLE. The memory must tolerate an abandoned request.
- Writes leave data_from_memory_mem unchanged.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a WAIT cycle counter clears on entering WAIT. When it reaches TIMEOUT_CYCLES without mem_ack: mem_req<=0, timeout_err<=1 (sticky); a read loads 32'hDEADBEEF; go to DONE.
- Undefined: WAIT lasts until mem_ack, there is no counter, and timeout_err is tied 0.

Decomposition:
- Shared header/package: state encodings MEM_ST_IDLE=2'd0, MEM_ST_WAIT=2'd1, MEM_ST_DONE=2'd2; the constant MEM_TIMEOUT_DATA=32'hDEADBEEF.
- One sub-module, mem_watchdog: the counter plus compare. It is instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Load, aligned: addr 0x0000_0010, ack 3 cycles after req → mem_addr=4, mem_we=0; data_ready_mem low for 4 cycles; data_from_memory_mem=mem_rdata=0x1234_5678 in DONE.
- Store: addr 0x20, data 0xCAFE_F00D, ack after 1 cycle → mem_we=1, mem_wdata=0xCAFE_F00D; data_from_memory_mem unchanged.
- Stall in DONE: alu_ready=0 for 5 cycles → mem_req pulses exactly once; data_ready_mem=1 throughout DONE; IDLE only after alu_ready=1.
- Misaligned load at 0x0000_0013 → no mem_req; data_ready_mem stays 1; misalign_err=1; misalign_addr=0x13. A second misaligned access at 0x21 leaves misalign_addr at 0x13.
- Reset asserted in WAIT → mem_req=0 and state IDLE immediately. After release with no access pending, data_ready_mem=1.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=8, ack never asserted → after 8 WAIT cycles: timeout_err=1, data_from_memory_mem=0xDEADBEEF, DONE reached.
